vote_detect: RTL and testbench

- Parametrised successor to the fixed 3-input OR detector: N asynchronous switch/pin inputs are synchronised, debounced per channel, and combined under a runtime-selectable mode (ANY, ALL, MAJORITY, THRESHOLD).
- The result is registered, with rise/fall event pulses and a population count.
- Sits directly behind the board input pads and drives an LED or the downstream control logic.

---
 rtl/vote_pkg.sv | 16 +
 rtl/vote_detect_if.sv | 29 ++
 rtl/vote_detect_debounce.sv | 39 +++
 rtl/vote_detect.sv | 78 +++++++
 tb/tb_vote_detect.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// vote_detect shared types: mode encodings and
// the count-width helper used by every file.
package vote_pkg;

  typedef enum logic [1:0] {
    MODE_ANY = 2'b00,
    MODE_ALL = 2'b01,
    MODE_MAJ = 2'b10,
    MODE_THR = 2'b11
  } vote_mode_t;

  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vote_detect_if.sv
// vote_detect channel/control/result bundle.
// master drives din/en/mode/thr, slave is the detector.
interface vote_detect_if #(
  parameter int N = 3
);
  import vote_pkg::*;

  localparam int CW = cw_of(N);

  logic [N-1:0]  din;
  logic          en;
  vote_mode_t    mode;
  logic [CW-1:0] thr;
  logic          y;
  logic          y_rise;
  logic          y_fall;
  logic [CW-1:0] ones_cnt;

  modport master (
    output din, en, mode, thr,
    input  y, y_rise, y_fall, ones_cnt
  );

  modport slave (
    input  din, en, mode, thr,
    output y, y_rise, y_fall, ones_cnt
  );

endinterface

// File: rtl/vote_detect_debounce.sv
// One channel: 2-flop synchroniser followed by a
// DB-cycle persistence filter feeding the stable bit.
module debounce_ch #(
  parameter int DB = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  localparam int DW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [DW-1:0] C_MAX = DW'(DB - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      c  <= '0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s2 == q) begin
        c <= '0;
      end else if (c == C_MAX) begin
        q <= s2;
        c <= '0;
      end else begin
        c <= c + DW'(1);
      end
    end
  end

endmodule

// File: rtl/vote_detect.sv
// N-channel debounced voter: popcount, mode mux,
// registered result with rise/fall event pulses.
module vote_detect
  import vote_pkg::*;
#(
  parameter int N  = 3,
  parameter int DB = 4
) (
  input logic          clk,
  input logic          rst_n,
  vote_detect_if.slave bus
);

  localparam int CW = cw_of(N);

  logic [N-1:0]  stable;
  logic [CW-1:0] k;
  logic          hit;
  logic          y_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    debounce_ch #(
      .DB(DB)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.din[gi]),
      .q    (stable[gi])
    );
  end

  always_comb begin
    k = '0;
    for (int j = 0; j < N; j++) begin
      k = k + CW'(stable[j]);
    end
  end

  always_comb begin
    hit = 1'b0;
    unique case (bus.mode)
      MODE_ANY: hit = (k != '0);
      MODE_ALL: hit = (k == CW'(N));
      MODE_MAJ: hit = ((2 * int'(k)) > N);
      MODE_THR: hit = (k >= bus.thr);
      default:  hit = 1'b0;
    endcase
  end

  // en only gates y and its pulses; the count always tracks stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= k;
      if (bus.en) begin
        y_q    <= hit;
        rise_q <= hit & ~y_q;
        fall_q <= ~hit & y_q;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end
    end
  end

  assign bus.y        = y_q;
  assign bus.y_rise   = rise_q;
  assign bus.y_fall   = fall_q;
  assign bus.ones_cnt = cnt_q;

endmodule

// File: tb/tb_vote_detect.sv
// Scoreboard bench for vote_detect: three instances
// (N=3/DB=4, N=4/DB=4, N=3/DB=1) on one clock.
module tb_vote_detect;
  import vote_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vote_detect_if #(.N(3)) ia ();
  vote_detect_if #(.N(4)) ib ();
  vote_detect_if #(.N(3)) ic ();

  vote_detect #(.N(3), .DB(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia)
  );
  vote_detect #(.N(4), .DB(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib)
  );
  vote_detect #(.N(3), .DB(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic)
  );

  typedef struct {
    int    cyc;
    int    dut;
    logic  y;
    logic  r;
    logic  f;
    int    cnt;
    string nm;
  } exp_t;

  exp_t sb[$];

  function automatic void expect_at(
    input int dut, input int off,
    input logic y, input logic r, input logic f,
    input int cnt, input string nm
  );
    exp_t e;
    e.cyc = cyc + off;
    e.dut = dut;
    e.y   = y;
    e.r   = r;
    e.f   = f;
    e.cnt = cnt;
    e.nm  = nm;
    sb.push_back(e);
  endfunction

  // monitor: compares every entry due at this edge
  always @(negedge clk) begin : mon
    int   i;
    logic gy, gr, gf;
    int   gc;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].dut)
          0: begin
            gy = ia.y; gr = ia.y_rise;
            gf = ia.y_fall; gc = int'(ia.ones_cnt);
          end
          1: begin
            gy = ib.y; gr = ib.y_rise;
            gf = ib.y_fall; gc = int'(ib.ones_cnt);
          end
          default: begin
            gy = ic.y; gr = ic.y_rise;
            gf = ic.y_fall; gc = int'(ic.ones_cnt);
          end
        endcase
        n_cmp++;
        if ({gy, gr, gf} !== {sb[i].y, sb[i].r, sb[i].f} ||
            gc != sb[i].cnt) begin
          n_bad++;
          $display("FAIL %s @%0d: got y=%b rise=%b fall=%b cnt=%0d, want y=%b rise=%b fall=%b cnt=%0d",
                   sb[i].nm, cyc, gy, gr, gf, gc,
                   sb[i].y, sb[i].r, sb[i].f, sb[i].cnt);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d never checked",
                 sb[i].nm, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ia.din  = '0; ia.en = 1'b1; ia.mode = MODE_ANY; ia.thr = '0;
    ib.din  = '0; ib.en = 1'b1; ib.mode = MODE_MAJ; ib.thr = '0;
    ic.din  = '0; ic.en = 1'b1; ic.mode = MODE_ANY; ic.thr = '0;
    tick(3);
    rst_n = 1'b1;

    // idle after reset
    for (int k = 1; k <= 20; k++) expect_at(0, k, 0, 0, 0, 0, "idle");
    tick(20);

    // ANY rise and fall latency
    ia.din = 3'b010;
    expect_at(0, 6, 0, 0, 0, 0, "any_pre");
    expect_at(0, 7, 1, 1, 0, 1, "any_rise");
    expect_at(0, 8, 1, 0, 0, 1, "any_hold");
    tick(10);
    ia.din = 3'b000;
    expect_at(0, 6, 1, 0, 0, 1, "any_prefall");
    expect_at(0, 7, 0, 0, 1, 0, "any_fall");
    expect_at(0, 8, 0, 0, 0, 0, "any_low");
    tick(10);

    // 3-cycle glitch rejected
    for (int k = 1; k <= 12; k += 2) expect_at(0, k, 0, 0, 0, 0, "glitch3");
    ia.din = 3'b001;
    tick(3);
    ia.din = 3'b000;
    tick(11);

    // 4-cycle pulse accepted
    expect_at(0, 6, 0, 0, 0, 0, "pulse4_pre");
    expect_at(0, 7, 1, 1, 0, 1, "pulse4_rise");
    expect_at(0, 10, 1, 0, 0, 1, "pulse4_hold");
    expect_at(0, 11, 0, 0, 1, 0, "pulse4_fall");
    expect_at(0, 12, 0, 0, 0, 0, "pulse4_low");
    ia.din = 3'b001;
    tick(4);
    ia.din = 3'b000;
    tick(10);

    // mode sweep at stable=011
    ia.din = 3'b011;
    expect_at(0, 7, 1, 1, 0, 2, "sweep_any");
    tick(10);
    ia.mode = MODE_ALL;
    expect_at(0, 1, 0, 0, 1, 2, "sweep_all");
    tick(2);
    ia.mode = MODE_MAJ;
    expect_at(0, 1, 1, 1, 0, 2, "sweep_maj");
    tick(2);
    ia.mode = MODE_THR; ia.thr = 2'd3;
    expect_at(0, 1, 0, 0, 1, 2, "sweep_thr3");
    tick(2);
    ia.thr = 2'd0;
    expect_at(0, 1, 1, 1, 0, 2, "sweep_thr0");
    tick(2);
    ia.mode = MODE_ANY;
    ia.din  = 3'b000;
    expect_at(0, 1, 1, 0, 0, 2, "sweep_back_any");
    expect_at(0, 7, 0, 0, 1, 0, "sweep_clear");
    tick(10);

    // en gating
    ia.en  = 1'b0;
    ia.din = 3'b111;
    expect_at(0, 7, 0, 0, 0, 3, "en_off_cnt");
    expect_at(0, 9, 0, 0, 0, 3, "en_off_hold");
    tick(10);
    ia.en = 1'b1;
    expect_at(0, 1, 1, 1, 0, 3, "en_on_rise");
    expect_at(0, 2, 1, 0, 0, 3, "en_on_hold");
    tick(3);

    // mid-run reset, then re-debounce of held 111
    rst_n = 1'b0;
    expect_at(0, 1, 0, 0, 0, 0, "rst_clear");
    expect_at(0, 2, 0, 0, 0, 0, "rst_hold");
    expect_at(0, 8, 0, 0, 0, 0, "rst_redebounce");
    expect_at(0, 9, 1, 1, 0, 3, "rst_rerise");
    tick(2);
    rst_n = 1'b1;
    tick(10);
    ia.din = 3'b000;
    tick(10);

    // N=4 majority tie and win
    ib.din = 4'b0011;
    expect_at(1, 7, 0, 0, 0, 2, "n4_tie");
    expect_at(1, 8, 0, 0, 0, 2, "n4_tie_hold");
    tick(10);
    ib.din = 4'b0111;
    expect_at(1, 6, 0, 0, 0, 2, "n4_pre");
    expect_at(1, 7, 1, 1, 0, 3, "n4_maj");
    tick(10);

    // DB=1 latency
    ic.din = 3'b100;
    expect_at(2, 3, 0, 0, 0, 0, "db1_pre");
    expect_at(2, 4, 1, 1, 0, 1, "db1_rise");
    expect_at(2, 5, 1, 0, 0, 1, "db1_hold");
    tick(8);

    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: left unchecked", sb[0].nm);
      sb.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
